// File: rtl/lsu_mem_if.sv
// lsu_mem_if: load/store unit bridging the core memory stage to a handshaked data bus
// Ports: req_* core request (req_ready accepts), busy stalls the core,
// rsp_* one-cycle completion with extended load data and error flag,
// mem_* word-aligned bus request with byte enables, gnt and rvalid handshakes.
module lsu_mem_if #(
  parameter int WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             req_ready,
  output logic             busy,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state, state_d;
  logic we_q;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic [31:0] cnt;
  logic acc, bad, tmo;
  logic [3:0] be_d;
  logic [WIDTH-1:0] wd_d, lane, ext;
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign rsp_valid = state == RESP;
  assign mem_req = state == REQ;
  assign mem_we = mem_req & we_q;
  assign acc = req_valid & req_ready;
  // stores only allow byte/half/word; halves need addr[0]=0, words addr[1:0]=0
  assign bad = req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11 || (req_we && req_funct3[2]) ||
               (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
               (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  // a handshake in the same cycle wins over the timeout
  assign tmo = TIMEOUT_CYCLES != 0 && cnt == 32'(TIMEOUT_CYCLES - 1) &&
               ((state == REQ && !mem_gnt) || (state == WAIT && !mem_rvalid));
  assign be_d = req_funct3[1:0] == 2'b00 ? 4'b0001 << req_addr[1:0] :
                req_funct3[1:0] == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wd_d = req_funct3[1:0] == 2'b00 ? {4{req_wdata[7:0]}} :
                req_funct3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
  assign lane = mem_rdata >> {off_q, 3'b000};
  // funct3[2] marks the unsigned loads
  assign ext = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & lane[7]}}, lane[7:0]} :
               f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & lane[15]}}, lane[15:0]} : lane;
  always_comb begin
    state_d = state;
    case (state)
      IDLE: state_d = acc ? (bad ? RESP : REQ) : IDLE;
      REQ:  state_d = mem_gnt ? (we_q ? RESP : WAIT) : tmo ? RESP : REQ;
      WAIT: state_d = (mem_rvalid || tmo) ? RESP : WAIT;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      we_q <= 1'b0;
      f3_q <= '0;
      off_q <= '0;
      mem_addr <= '0;
      mem_be <= '0;
      mem_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_d;
      cnt <= (state == IDLE || state_d != state) ? '0 : cnt + 32'd1;
      if (acc) begin
        we_q <= req_we;
        f3_q <= req_funct3;
        off_q <= req_addr[1:0];
        mem_addr <= {req_addr[WIDTH-1:2], 2'b00};
        mem_be <= be_d;
        mem_wdata <= wd_d;
        rsp_rdata <= '0;
        rsp_err <= bad;
      end
      if (state == WAIT && mem_rvalid) rsp_rdata <= ext;
      if (tmo) rsp_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_lsu_mem_if.sv
// tb_lsu_mem_if: directed checks of lsu_mem_if loads, stores, errors, timeout and reset
module tb_lsu_mem_if;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_valid_t = 1'b0, req_we = 1'b0;
  logic [2:0] req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
  logic mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic req_ready, busy, rsp_valid, rsp_err, mem_req, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  logic t_ready, t_busy, t_valid, t_err, t_req, t_we;
  logic [31:0] t_rdata, t_addr, t_wdata;
  logic [3:0] t_be;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  lsu_mem_if dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .busy(busy),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );
  lsu_mem_if #(.TIMEOUT_CYCLES(4)) dut_t (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_t), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(t_ready), .busy(t_busy),
    .rsp_valid(t_valid), .rsp_rdata(t_rdata), .rsp_err(t_err), .mem_req(t_req),
    .mem_we(t_we), .mem_addr(t_addr), .mem_be(t_be), .mem_wdata(t_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic op(input logic t, input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_we = we;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    if (t) req_valid_t = 1'b1;
    else req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    req_valid_t = 1'b0;
  endtask
  task automatic load_imm(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rd, input logic [3:0] be, input logic [31:0] exp);
    mem_gnt = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = rd;
    op(1'b0, 1'b0, f3, a, 32'h0);
    chk({tag, "_req"}, 32'(mem_req), 32'd1);
    chk({tag, "_be"}, 32'(mem_be), 32'(be));
    chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
    step();
    chk({tag, "_wait"}, 32'(rsp_valid), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rdata"}, rsp_rdata, exp);
    chk({tag, "_err"}, 32'(rsp_err), 32'd0);
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    step();
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask
  task automatic err_case(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a);
    op(1'b0, we, f3, a, 32'h1234_5678);
    chk({tag, "_nomemreq"}, 32'(mem_req), 32'd0);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_err"}, 32'(rsp_err), 32'd1);
    chk({tag, "_rdata"}, rsp_rdata, 32'h0);
    step();
    chk({tag, "_idle"}, 32'(req_ready), 32'd1);
  endtask
  initial begin
    #2;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_memreq", 32'(mem_req), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    load_imm("lw", 3'b010, 32'h100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    load_imm("lb", 3'b000, 32'h103, 32'h8012_3456, 4'b1000, 32'hFFFF_FF80);
    load_imm("lbu", 3'b100, 32'h103, 32'h8012_3456, 4'b1000, 32'h0000_0080);
    load_imm("lh", 3'b001, 32'h102, 32'h8001_1234, 4'b1100, 32'hFFFF_8001);
    load_imm("lhu", 3'b101, 32'h100, 32'h1234_ABCD, 4'b0011, 32'h0000_ABCD);
    load_imm("lb1", 3'b000, 32'h101, 32'h0000_7F00, 4'b0010, 32'h0000_007F);
    op(1'b0, 1'b1, 3'b000, 32'h201, 32'h0000_00AB);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) mem_gnt = 1'b1;
      chk("sb_req", 32'(mem_req), 32'd1);
      chk("sb_we", 32'(mem_we), 32'd1);
      chk("sb_be", 32'(mem_be), 32'b0010);
      chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
      chk("sb_addr", mem_addr, 32'h200);
      step();
    end
    mem_gnt = 1'b0;
    chk("sb_valid", 32'(rsp_valid), 32'd1);
    chk("sb_err", 32'(rsp_err), 32'd0);
    chk("sb_rdata", rsp_rdata, 32'h0);
    chk("sb_memreq_off", 32'(mem_req), 32'd0);
    step();
    chk("sb_idle", 32'(rsp_valid), 32'd0);
    mem_gnt = 1'b1;
    op(1'b0, 1'b1, 3'b001, 32'h302, 32'h0000_CDEF);
    chk("sh_be", 32'(mem_be), 32'b1100);
    chk("sh_wdata", mem_wdata, 32'hCDEF_CDEF);
    step();
    mem_gnt = 1'b0;
    chk("sh_valid", 32'(rsp_valid), 32'd1);
    step();
    err_case("lw_mis", 1'b0, 3'b010, 32'h102);
    err_case("sh_mis", 1'b1, 3'b001, 32'h301);
    err_case("f3_011", 1'b0, 3'b011, 32'h100);
    err_case("st_f3_100", 1'b1, 3'b100, 32'h100);
    mem_gnt = 1'b1;
    op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    chk("to_req", 32'(t_req), 32'd1);
    step();
    mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_waiting", 32'(t_valid), 32'd0);
      chk("to_busy", 32'(t_busy), 32'd1);
      step();
    end
    chk("to_valid", 32'(t_valid), 32'd1);
    chk("to_err", 32'(t_err), 32'd1);
    chk("to_rdata", t_rdata, 32'h0);
    step();
    mem_rvalid = 1'b1;
    mem_rdata = 32'h5555_5555;
    step();
    mem_rvalid = 1'b0;
    chk("to_late_valid", 32'(t_valid), 32'd0);
    chk("to_late_ready", 32'(t_ready), 32'd1);
    op(1'b0, 1'b0, 3'b010, 32'h400, 32'h0);
    chk("rst_mid_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_memreq", 32'(mem_req), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
    step();
    rst_n = 1'b1;
    mem_gnt = 1'b1;
    step();
    chk("rst_post_valid", 32'(rsp_valid), 32'd0);
    chk("rst_post_ready", 32'(req_ready), 32'd1);
    load_imm("lw_after_rst", 3'b010, 32'h500, 32'h1234_5678, 4'b1111, 32'h1234_5678);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
